// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, registered carry.
// Optional signed-overflow output is enabled with `define SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is accepted only in IDLE or DONE (ignored while busy);
  // done is a one-cycle pulse, and sum/c_out/ovf hold until the next accepted start.
  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] sum_next;
  logic             last;
  logic             accept;

  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  end

  // New digit enters from the MSB side so the LSB digit ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign sum_next = dsum[DIGIT-1:0];
  end else begin : g_multi
    assign sum_next = {dsum[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
  end

  assign last   = (cnt == CW'(STEPS - 1));
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          sum   <= sum_next;
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          carry <= dsum[DIGIT];
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            // carry into MSB = a^b^s at the MSB; overflow = that XOR carry out
            ovf   <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= c_in ^ sub;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: four instances (8/1, 8/4, 8/2, 4/1) share
// operand inputs; each has its own start so one instance runs at a time.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sub = 1'b0;
  logic       c_in = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       st0 = 1'b0, st1 = 1'b0, st2 = 1'b0, st3 = 1'b0;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic       cout0, cout1, cout2, cout3;
  logic [7:0] sum0, sum1, sum2;
  logic [3:0] sum3;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf0, ovf1, ovf2, ovf3;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cur      = 0;

  logic       m_busy, m_done, m_cout, m_ovf;
  logic [7:0] m_sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(st0), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(cout0)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(st1), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(st2), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst(rst), .start(st3), .sub(sub), .a(a[3:0]), .b(b[3:0]), .c_in(c_in),
    .busy(busy3), .done(done3), .sum(sum3), .c_out(cout3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  always_comb begin
    m_busy = busy0;
    m_done = done0;
    m_sum  = sum0;
    m_cout = cout0;
    m_ovf  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    m_ovf  = ovf0;
`endif
    case (cur)
      1: begin
        m_busy = busy1; m_done = done1; m_sum = sum1; m_cout = cout1;
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf = ovf1;
`endif
      end
      2: begin
        m_busy = busy2; m_done = done2; m_sum = sum2; m_cout = cout2;
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf = ovf2;
`endif
      end
      3: begin
        m_busy = busy3; m_done = done3; m_sum = {4'h0, sum3}; m_cout = cout3;
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf = ovf3;
`endif
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: st0 = v;
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  // Returns on the negedge where done is seen (or the bound expires).
  task automatic run_op(input int sel, input logic [7:0] aa, input logic [7:0] bb,
                        input logic ci, input logic s, input int exp_lat,
                        input logic [7:0] exp_sum, input logic exp_c,
                        input logic exp_v, input string tag);
    int lat;
    cur = sel;
    @(negedge clk);
    a = aa; b = bb; c_in = ci; sub = s;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    a = ~aa; b = ~bb; c_in = ~ci; sub = ~s;
    check({tag, "/busy"}, 32'(m_busy), 32'd1);
    lat = 0;
    while (m_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/sum"}, 32'(m_sum), 32'(exp_sum));
    check({tag, "/c_out"}, 32'(m_cout), 32'(exp_c));
    check({tag, "/busy_at_done"}, 32'(m_busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "/ovf"}, 32'(m_ovf), 32'(exp_v));
`else
    if (exp_v === 1'bx) $display("unexpected x in ovf expectation for %s", tag);
`endif
  endtask

  initial begin
    int p;
    int seen;
    int r, sr, sa, sb;
    logic [7:0] es;
    logic ec, ev;

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst/busy", 32'(busy0), 32'd0);
    check("rst/done", 32'(done0), 32'd0);
    check("rst/sum", 32'(sum0), 32'd0);
    check("rst/c_out", 32'(cout0), 32'd0);
    cur = 3;
    check("rst/sum_w4", 32'(m_sum), 32'd0);
    check("rst/ovf_w4", 32'(m_ovf), 32'd0);
    cur = 0;

    // directed arithmetic
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b0, "add_cout_d1");
    repeat (4) @(negedge clk);
    check("hold/sum", 32'(m_sum), 32'h00);
    check("hold/c_out", 32'(m_cout), 32'd1);
    run_op(1, 8'h7F, 8'h00, 1'b1, 1'b0, 2, 8'h80, 1'b0, 1'b1, "add_cin_ovf_d4");
    run_op(2, 8'h05, 8'h07, 1'b0, 1'b1, 4, 8'hFE, 1'b0, 1'b0, "sub_borrow_d2");
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8, 8'h7F, 1'b1, 1'b1, "sub_ovf_d1");
    run_op(1, 8'h12, 8'h34, 1'b1, 1'b0, 2, 8'h47, 1'b0, 1'b0, "add_d4");
    run_op(2, 8'h10, 8'h01, 1'b1, 1'b1, 4, 8'h0E, 1'b1, 1'b0, "sub_bin_d2");

    // back-to-back with start held high; mid-run operand changes ignored
    cur = 0;
    @(negedge clk);
    a = 8'h03; b = 8'h04; c_in = 1'b0; sub = 1'b0; st0 = 1'b1;
    @(negedge clk);
    check("b2b/busy", 32'(m_busy), 32'd1);
    a = 8'hAA; b = 8'h55;
    p = 0;
    while (m_done !== 1'b1 && p < 40) begin
      @(negedge clk);
      p++;
    end
    check("b2b/lat1", 32'(p), 32'd8);
    check("b2b/sum1", 32'(m_sum), 32'h07);
    a = 8'h10; b = 8'h01;
    @(negedge clk);
    check("b2b/done_drop", 32'(m_done), 32'd0);
    check("b2b/busy2", 32'(m_busy), 32'd1);
    check("b2b/sum_clr", 32'(m_sum), 32'd0);
    a = 8'hEE; b = 8'hEE;
    p = 1;
    while (m_done !== 1'b1 && p < 40) begin
      @(negedge clk);
      p++;
    end
    check("b2b/period", 32'(p), 32'd9);
    check("b2b/sum2", 32'(m_sum), 32'h11);
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b/sum_hold", 32'(m_sum), 32'h11);
    check("b2b/idle_done", 32'(m_done), 32'd0);

    // mid-run reset
    @(negedge clk);
    a = 8'h55; b = 8'h11; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst/busy", 32'(busy0), 32'd0);
    check("midrst/done", 32'(done0), 32'd0);
    check("midrst/sum", 32'(sum0), 32'd0);
    check("midrst/c_out", 32'(cout0), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) seen = 1;
    end
    check("midrst/no_done", 32'(seen), 32'd0);
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8, 8'h30, 1'b0, 1'b0, "after_rst");

    // rst wins over simultaneous start
    @(negedge clk);
    rst = 1'b1; st0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; st0 = 1'b0;
    check("rst_start/busy", 32'(busy0), 32'd0);
    check("rst_start/sum", 32'(sum0), 32'd0);

    // exhaustive 4-bit, DIGIT=1
    for (int s = 0; s < 2; s++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            sa = (ai >= 8) ? ai - 16 : ai;
            sb = (bi >= 8) ? bi - 16 : bi;
            if (s == 0) begin
              r  = ai + bi + ci;
              ec = (r > 15);
              sr = sa + sb + ci;
            end else begin
              r  = ai - bi - ci;
              ec = (r >= 0);
              sr = sa - sb - ci;
            end
            es = 8'(r & 15);
            ev = (sr > 7) || (sr < -8);
            run_op(3, 8'(ai), 8'(bi), 1'(ci), 1'(s), 4, es, ec, ev,
                   $sformatf("exh_s%0d_c%0d_a%0h_b%0h", s, ci, ai, bi));
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
